march_bist_ctrl: RTL and testbench
==================================

# march_bist_ctrl

Parametrised March memory-BIST controller and functional/test mux for a single-port synchronous SRAM. It generalises the existing fixed 8×8 BIST to configurable address and data widths. It adds selectable March algorithms (MATS+, March C-), a solid or checkerboard data background, failure-address capture and a saturating mismatch counter. It sits between the functional RAM user and the RAM macro. With `opr`=1 it owns the RAM port; with `opr`=0 it is transparent.

## Interface
- `size`, 8: address width; RAM depth N = 2^size.
- `length`, 8: data width.
- `CNT_W`, 8: width of `fail_cnt`.
- `clk  in  1`: single clock, all logic on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `start  in  1`: level request to run a test; sampled only in IDLE with `opr`=1.
- `opr  in  1`: 1 = BIST owns the RAM, 0 = functional pass-through.
- `mode  in  1`: 0 = MATS+, 1 = March C-; sampled at start.
- `bg  in  1`: 0 = solid background, 1 = checkerboard; sampled at start.
- `csin  in  1`, `rwbarin  in  1`, `address  in  size`, `datain  in  length`: functional RAM request (`rwbarin`=1 read).
- `dataout  out  length`: functional read data.
- `mem_cs  out  1`, `mem_we  out  1`, `mem_addr  out  size`, `mem_wdata  out  length`: RAM port.
- `mem_rdata  in  length`: RAM read data, valid the cycle after a read.
- `busy  out  1`, `done  out  1`, `fail  out  1`: status.
- `fail_addr  out  size`: address of the first mismatch.
- `fail_cnt  out  CNT_W`: saturating mismatch count.
- `elem  out  3`: current March element index.

## Operation
- **States.**
  - IDLE: `start`&`opr` → RUN. On this transition, latch `mode`/`bg`, clear `fail`/`fail_cnt`/`fail_addr`, set the element to 0 and the address to the element's start address.
  - RUN: issue one RAM operation per cycle. The last op of the last element → DRAIN.
  - DRAIN: one cycle to compare the final read → DONE.
  - DONE: `done`=1; results held; `start`=0 → IDLE.
- **Algorithms** (⇕ treated as ⇑):
  - MATS+: {⇕w0; ⇑(r0,w1); ⇓(r1,w0)}; 5N ops.
  - March C-: {⇕w0; ⇑(r0,w1); ⇑(r1,w0); ⇓(r0,w1); ⇓(r1,w0); ⇕r0}; 10N ops.
- **Address sequencing.**
  - Within a multi-op element, all ops are applied at one address before it advances.
  - ⇑ runs 0→N−1; ⇓ runs N−1→0.
  - The address counter wraps naturally at width `size`; the element ends on the terminal address.
- **Background** P(a).
  - Solid: P = all-zeros.
  - Checkerboard: P = a[0] ? 0xAA.. : 0x55.. (alternating bits, `length` wide, MSB=1 for odd addresses).
  - "0" writes/expects P(a); "1" writes/expects ~P(a).
- **Compare.**
  - Read address and expected data are registered alongside the read.
  - The compare happens the next cycle against `mem_rdata`.
  - On mismatch: `fail`←1 (sticky). `fail_addr` is captured only on the first mismatch. `fail_cnt` increments and saturates at 2^CNT_W−1.
  - The test always runs to completion; there is no stop-on-fail.
- **Mux.**
  - `opr`=0: `mem_cs`=`csin`, `mem_we`=`csin`&~`rwbarin`, `mem_addr`=`address`, `mem_wdata`=`datain`, `dataout`=`mem_rdata`.
  - `opr`=1: BIST drives the RAM port; `dataout`=0; `mem_cs`=1 only in RUN.
- **Boundary conditions.**
  - `start` high while RUN/DRAIN/DONE: ignored.
  - `opr`→0 during RUN/DRAIN: abort to IDLE next edge. `busy`=0, `done` stays 0, `fail`/`fail_cnt` keep partial values.
  - `mode`/`bg` changes mid-run: no effect.
  - `start` held high through DONE: remain in DONE, no auto-restart.
  - Reset mid-run: immediate return to IDLE with all outputs at reset values.

## Timing
- **Reset values.**
  - `busy`, `done`, `fail`, `fail_addr`, `fail_cnt`, `elem` = 0.
  - State = IDLE.
  - Internal registers cleared. RAM port outputs follow the mux, so with `opr`=0 they are combinational from the functional inputs.
- **Run latency.**
  - Edge E0 samples `start`. The first RAM op is driven in the cycle after E0. Op k (1..K) is in cycle k.
  - DRAIN is cycle K+1. `done`=1 from cycle K+2, i.e. E0+K+2 edges.
  - K = 5N (MATS+) or 10N (March C-).
- **Status timing.**
  - `busy`=1 in RUN and DRAIN.
  - `fail` rises the cycle after the mismatching `mem_rdata` is presented.
  - `elem` updates on the edge that starts the element's first op.
- **Pass-through:** zero added latency (combinational).

## Test plan
- **MATS+ clean.** `size`=4, `length`=8, fault-free RAM model, `mode`=0, `bg`=0, pulse `start` → `done` at cycle 82, `fail`=0, `fail_cnt`=0.
- **March C- stuck-at-0.** `mode`=1, bg solid; bit 3 of address 5 stuck-at-0 → `done` at cycle 162, `fail`=1, `fail_addr`=5, `fail_cnt`=2 (two r1 elements).
- **MATS+ checkerboard, same fault.** `mode`=0, `bg`=1, same stuck-at-0 → expected 0xAA at address 5 in element 1, read 0xA2 → `fail_cnt`=1, `fail_addr`=5. Also check `mem_wdata`=0x55 at address 4 in element 0.
- **Abort.** `opr`→0 at cycle 30 of a run → next cycle `busy`=0, `done`=0, and a functional write/read to address 3 with 0x3C returns `dataout`=0x3C.
- **Reset and restart.** Assert `rst`=0 mid-DRAIN → all status outputs 0 asynchronously. Rerun → identical clean result. `start` held high in DONE → no second run.
- **Counter saturation.** `CNT_W`=2, all-bits-stuck RAM, March C- → `fail_cnt`=3, `fail_addr`=0.

Source files
------------

// File: rtl/march_bist_ctrl_if.sv
// march_bist_ctrl_if: single-port synchronous SRAM port between the BIST/mux and the RAM macro.
interface march_bist_ctrl_if #(
    parameter int size   = 8,
    parameter int length = 8
);
    logic              mem_cs;
    logic              mem_we;
    logic [size-1:0]   mem_addr;
    logic [length-1:0] mem_wdata;
    logic [length-1:0] mem_rdata;

    modport master(output mem_cs, mem_we, mem_addr, mem_wdata, input mem_rdata);
    modport slave(input mem_cs, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl: March (MATS+ / March C-) memory BIST with failure capture, muxed with the functional RAM port.
module march_bist_ctrl #(
    parameter int size   = 8,
    parameter int length = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 opr,
    input  logic                 mode,
    input  logic                 bg,
    input  logic                 csin,
    input  logic                 rwbarin,
    input  logic [size-1:0]      address,
    input  logic [length-1:0]    datain,
    output logic [length-1:0]    dataout,
    march_bist_ctrl_if.master    mem,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [size-1:0]      fail_addr,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [2:0]           elem
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d, bg_q, bg_d, op_q, op_d;
    logic              rd_pend_q, rd_pend_d, fail_q, fail_d;
    logic [2:0]        elem_q, elem_d;
    logic [size-1:0]   addr_q, addr_d, rd_addr_q, rd_addr_d, fail_addr_q, fail_addr_d;
    logic [length-1:0] exp_q, exp_d, pat, wdata;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic              two, is_rd, val, down, term, last_elem, mism;

    function automatic logic is_down(input logic m, input logic [2:0] e);
        return m ? (e == 3'd3 || e == 3'd4) : e == 3'd2;
    endfunction

    always_comb begin
        for (int i = 0; i < length; i++) pat[i] = bg_q & ~(addr_q[0] ^ i[0]);
        // Two-op elements read v then write ~v, with v alternating 0,1,0,1 from element 1
        two       = elem_q != 3'd0 && !(mode_q && elem_q == 3'd5);
        is_rd     = two ? !op_q : elem_q != 3'd0;
        val       = two & (op_q ? elem_q[0] : ~elem_q[0]);
        down      = is_down(mode_q, elem_q);
        term      = addr_q == {size{~down}};
        last_elem = elem_q == (mode_q ? 3'd5 : 3'd2);
        wdata     = val ? ~pat : pat;
        mism      = rd_pend_q && mem.mem_rdata != exp_q;
        state_d     = state_q;
        mode_d      = mode_q;
        bg_d        = bg_q;
        op_d        = op_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        rd_pend_d   = state_q == RUN && opr && is_rd;
        exp_d       = wdata;
        rd_addr_d   = addr_q;
        fail_d      = fail_q | mism;
        fail_addr_d = (mism && !fail_q) ? rd_addr_q : fail_addr_q;
        fail_cnt_d  = fail_cnt_q + CNT_W'(mism && fail_cnt_q != '1);
        case (state_q)
            IDLE: if (start && opr) begin
                state_d     = RUN;
                mode_d      = mode;
                bg_d        = bg;
                fail_d      = 1'b0;
                fail_cnt_d  = '0;
                fail_addr_d = '0;
                elem_d      = 3'd0;
                op_d        = 1'b0;
                addr_d      = '0;
            end
            RUN: begin
                if (!opr) state_d = IDLE;
                else if (two && !op_q) op_d = 1'b1;
                else begin
                    op_d = 1'b0;
                    if (!term) addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
                    else if (last_elem) state_d = DRAIN;
                    else begin
                        elem_d = elem_q + 3'd1;
                        addr_d = {size{is_down(mode_q, elem_q + 3'd1)}};
                    end
                end
            end
            DRAIN: state_d = opr ? DONE : IDLE;
            DONE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            bg_q        <= 1'b0;
            op_q        <= 1'b0;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            rd_pend_q   <= 1'b0;
            exp_q       <= '0;
            rd_addr_q   <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bg_q        <= bg_d;
            op_q        <= op_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            rd_pend_q   <= rd_pend_d;
            exp_q       <= exp_d;
            rd_addr_q   <= rd_addr_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign busy          = state_q == RUN || state_q == DRAIN;
    assign done          = state_q == DONE;
    assign fail          = fail_q;
    assign fail_addr     = fail_addr_q;
    assign fail_cnt      = fail_cnt_q;
    assign elem          = elem_q;
    assign mem.mem_cs    = opr ? state_q == RUN : csin;
    assign mem.mem_we    = opr ? (state_q == RUN && !is_rd) : (csin & ~rwbarin);
    assign mem.mem_addr  = opr ? addr_q : address;
    assign mem.mem_wdata = opr ? wdata : datain;
    assign dataout       = opr ? '0 : mem.mem_rdata;
endmodule

// File: tb/tb_march_bist_ctrl.sv
// tb_march_bist_ctrl: directed checks of the March BIST controller against behavioural RAMs with injectable faults.
module tb_march_bist_ctrl;
    logic       clk, rst, start, start2, opr, mode, bg, csin, rwbarin, fault_en;
    logic [3:0] address;
    logic [7:0] datain, dataout, dataout2, w4;
    logic       busy, done, fail, busy2, done2, fail2;
    logic [3:0] fail_addr, fail_addr2;
    logic [7:0] fail_cnt;
    logic [1:0] fail_cnt2;
    logic [2:0] elem, elem2;
    logic [7:0] ram [16];
    int         checks, errors, cyc, cs_cnt;

    march_bist_ctrl_if #(.size(4), .length(8)) mem_if ();
    march_bist_ctrl_if #(.size(4), .length(8)) mem_if2 ();

    march_bist_ctrl #(.size(4), .length(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .opr(opr), .mode(mode), .bg(bg),
        .csin(csin), .rwbarin(rwbarin), .address(address), .datain(datain), .dataout(dataout),
        .mem(mem_if.master), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_cnt(fail_cnt), .elem(elem));

    march_bist_ctrl #(.size(4), .length(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .opr(opr), .mode(mode), .bg(bg),
        .csin(csin), .rwbarin(rwbarin), .address(address), .datain(datain), .dataout(dataout2),
        .mem(mem_if2.master), .busy(busy2), .done(done2), .fail(fail2),
        .fail_addr(fail_addr2), .fail_cnt(fail_cnt2), .elem(elem2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fault model: bit 3 of address 5 stuck at 0 when fault_en is set
    always @(posedge clk) begin
        if (mem_if.mem_cs && mem_if.mem_we) ram[mem_if.mem_addr] <= mem_if.mem_wdata;
        else if (mem_if.mem_cs)
            mem_if.mem_rdata <= ram[mem_if.mem_addr] & ((fault_en && mem_if.mem_addr == 4'd5) ? 8'hF7 : 8'hFF);
    end

    // Second RAM has every bit stuck at 0
    always @(posedge clk) if (mem_if2.mem_cs && !mem_if2.mem_we) mem_if2.mem_rdata <= 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic m, input logic b);
        mode  = m;
        bg    = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (!done && c < 400) begin
            tick();
            c++;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; start = 1'b0; start2 = 1'b0; opr = 1'b1; mode = 1'b0; bg = 1'b0;
        csin = 1'b0; rwbarin = 1'b1; address = '0; datain = '0; fault_en = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_elem", elem, 0);
        check("idle_cs", mem_if.mem_cs, 0);
        rst = 1'b1;
        tick();

        start_run(1'b0, 1'b0);
        mode = 1'b1;
        bg   = 1'b1;
        check("bist_dataout", dataout, 0);
        check("run_busy", busy, 1);
        wait_done(cyc);
        check("mats_done_cyc", cyc, 82);
        check("mats_fail", fail, 0);
        check("mats_fail_cnt", fail_cnt, 0);
        check("mats_elem", elem, 2);
        check("mats_busy", busy, 0);
        tick();
        check("back_idle", done, 0);

        fault_en = 1'b1;
        start_run(1'b1, 1'b0);
        wait_done(cyc);
        check("marchc_done_cyc", cyc, 162);
        check("marchc_fail", fail, 1);
        check("marchc_fail_addr", fail_addr, 5);
        check("marchc_fail_cnt", fail_cnt, 2);
        check("marchc_elem", elem, 5);
        tick();

        start_run(1'b0, 1'b1);
        w4  = 8'h00;
        cyc = 1;
        while (!done && cyc < 400) begin
            if (elem == 3'd0 && mem_if.mem_we && mem_if.mem_addr == 4'd4) w4 = mem_if.mem_wdata;
            tick();
            cyc++;
        end
        check("cb_done_cyc", cyc, 82);
        check("cb_wdata_a4", w4, 8'h55);
        check("cb_fail_cnt", fail_cnt, 1);
        check("cb_fail_addr", fail_addr, 5);
        fault_en = 1'b0;
        tick();

        start_run(1'b0, 1'b0);
        repeat (29) tick();
        opr = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        csin = 1'b1; rwbarin = 1'b0; address = 4'd3; datain = 8'h3C;
        #1;
        check("pass_we", mem_if.mem_we, 1);
        check("pass_addr", mem_if.mem_addr, 3);
        tick();
        rwbarin = 1'b1;
        tick();
        check("pass_dataout", dataout, 8'h3C);
        csin = 1'b0;
        opr  = 1'b1;
        tick();

        fault_en = 1'b1;
        start_run(1'b0, 1'b0);
        repeat (80) tick();
        check("drain_busy", busy, 1);
        check("drain_fail", fail, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_fail", fail, 0);
        check("arst_fail_cnt", fail_cnt, 0);
        check("arst_fail_addr", fail_addr, 0);
        check("arst_elem", elem, 0);
        fault_en = 1'b0;
        rst = 1'b1;
        tick();
        start_run(1'b0, 1'b0);
        wait_done(cyc);
        check("rerun_done_cyc", cyc, 82);
        check("rerun_fail", fail, 0);
        start  = 1'b1;
        cs_cnt = 0;
        repeat (20) begin
            tick();
            if (mem_if.mem_cs) cs_cnt++;
        end
        check("hold_done", done, 1);
        check("hold_no_rerun", cs_cnt, 0);
        start = 1'b0;
        tick();
        check("release_idle", done, 0);

        mode   = 1'b1;
        bg     = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 400) begin
            tick();
            cyc++;
        end
        check("sat_done_cyc", cyc, 162);
        check("sat_fail", fail2, 1);
        check("sat_fail_cnt", fail_cnt2, 3);
        check("sat_fail_addr", fail_addr2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
